// File: rtl/dm_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : dm_sram_responder
// Description : CPU data-memory responder. Word SRAM with byte write enables,
//               registered read port and a zero-fill sweep after reset.
// Revision    : 1.0
// ============================================================================
module dm_sram_responder #(
  parameter int ADDR_W    = 14,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_OE,
  input  logic [3:0]        DM_WEB,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [31:0]       DM_DI,
  output logic [31:0]       DM_DO,
  output logic              dm_ready,
  output logic              dm_err
);

  localparam int                c_depth     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] c_last_addr = '1;

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [31:0]       r_do;
  logic              r_ready;
  logic              r_err;
  logic [31:0]       r_mem [c_depth];

  logic [31:0]       w_old;
  logic [31:0]       w_merged;
  logic              w_wr_req;
  logic              w_access;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [31:0]       w_mem_wdata;

  assign w_old    = r_mem[DM_addr];
  assign w_wr_req = (DM_WEB != 4'hF);
  assign w_access = DM_OE || w_wr_req;

  // Merged word serves both the write port and the write-first read path.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign w_merged[8*i +: 8] = DM_WEB[i] ? w_old[8*i +: 8] : DM_DI[8*i +: 8];
  end

  assign w_mem_we    = rst && ((r_state == S_INIT) || w_wr_req);
  assign w_mem_addr  = (r_state == S_INIT) ? r_cnt : DM_addr;
  assign w_mem_wdata = (r_state == S_INIT) ? 32'h0 : w_merged;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= INIT_ZERO ? S_INIT : S_READY;
      r_cnt   <= '0;
      r_do    <= 32'h0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (w_access) begin
            r_err <= 1'b1;
          end
          // Counter parks on the last word; the final zero is written on the exit edge.
          if (r_cnt == c_last_addr) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_READY: begin
          r_ready <= 1'b1;
          if (DM_OE) begin
            r_do <= w_merged;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign DM_DO    = r_do;
  assign dm_ready = r_ready;
  assign dm_err   = r_err;

endmodule
`default_nettype wire
